id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core.
- Captures decoded fields plus the asynchronous RD1/RD2 outputs of the register file, and presents them to EX.
- Adds a write-back bypass, because the register file writes at the clock edge and a same-cycle read returns the stale value.
- Forces x0 to read as zero, detects load-use hazards and inserts a bubble, and honours stall/flush from the hazard controller.

---
 rtl/id_ex_stage_pkg.sv | 14 +
 rtl/id_ex_stage_operand_bypass.sv | 23 ++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control-bundle bit positions and register constants for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned CTRL_W        = 16;

  // Bit positions inside the opaque decoded control bundle
  localparam int unsigned LOAD_BIT      = 0;
  localparam int unsigned REG_WRITE_BIT = 1;
  localparam int unsigned MEM_WRITE_BIT = 2;

  localparam logic [4:0]  REG_ZERO      = 5'd0;

endpackage

// File: rtl/id_ex_stage_operand_bypass.sv
// Selects one EX operand: x0 reads zero, a same-cycle write-back wins over the stale RF read.
module operand_bypass #(
  parameter int unsigned XLEN = id_ex_stage_pkg::XLEN
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rf_rd,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op
);
  import id_ex_stage_pkg::*;

  always_comb begin
    op = rf_rd;
    if (rs == REG_ZERO) begin
      op = '0;
    end else if (wb_we && (wb_rd == rs)) begin
      op = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, x0 masking, load-use bubble and stall/flush.
module id_ex_stage #(
  parameter int unsigned XLEN     = id_ex_stage_pkg::XLEN,
  parameter int unsigned CTRL_W   = id_ex_stage_pkg::CTRL_W,
  parameter int unsigned LOAD_BIT = id_ex_stage_pkg::LOAD_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_hold,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2
);
  import id_ex_stage_pkg::*;

  logic              ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q,    ex_pc_d;
  logic [XLEN-1:0]   ex_imm_q,   ex_imm_d;
  logic [4:0]        ex_rs1_q,   ex_rs1_d;
  logic [4:0]        ex_rs2_q,   ex_rs2_d;
  logic [4:0]        ex_rd_q,    ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [XLEN-1:0]   ex_op1_q,   ex_op1_d;
  logic [XLEN-1:0]   ex_op2_q,   ex_op2_d;

  logic [XLEN-1:0]   op1_sel;
  logic [XLEN-1:0]   op2_sel;
  logic              load_use;

  operand_bypass #(.XLEN(XLEN)) u_bypass_op1 (
    .rs      (id_rs1),
    .rf_rd   (rf_rd1),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .op      (op1_sel)
  );

  operand_bypass #(.XLEN(XLEN)) u_bypass_op2 (
    .rs      (id_rs2),
    .rf_rd   (rf_rd2),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .op      (op2_sel)
  );

  // Conservative: a match on either source index stalls, whether or not the source is used
  assign load_use = id_valid & ex_valid_q & ex_ctrl_q[LOAD_BIT] & (ex_rd_q != REG_ZERO) &
                    ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

  assign id_hold = ~rst & (stall | load_use);

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_imm_d   = ex_imm_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_rd_d    = ex_rd_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_op1_d   = ex_op1_q;
    ex_op2_d   = ex_op2_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (stall) begin
      ex_valid_d = ex_valid_q;
    end else if (load_use) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end else begin
      ex_valid_d = id_valid;
      ex_pc_d    = id_pc;
      ex_imm_d   = id_imm;
      ex_rs1_d   = id_rs1;
      ex_rs2_d   = id_rs2;
      ex_rd_d    = id_rd;
      ex_ctrl_d  = id_ctrl;
      ex_op1_d   = op1_sel;
      ex_op2_d   = op2_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_imm_q   <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_ctrl_q  <= '0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_op1_q   <= ex_op1_d;
      ex_op2_q   <= ex_op2_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_pc    = ex_pc_q;
  assign ex_imm   = ex_imm_q;
  assign ex_rs1   = ex_rs1_q;
  assign ex_rs2   = ex_rs2_q;
  assign ex_rd    = ex_rd_q;
  assign ex_ctrl  = ex_ctrl_q;
  assign ex_op1   = ex_op1_q;
  assign ex_op2   = ex_op2_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a register-file-level model predicts the EX contents each edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic [4:0]  id_rd = '0;
  logic [31:0] id_imm = '0;
  logic [15:0] id_ctrl = '0;
  logic [31:0] rf_rd1 = '0;
  logic [31:0] rf_rd2 = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        id_hold;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_ctrl;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_hold(id_hold), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_op1(ex_op1), .ex_op2(ex_op2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, flush;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, imm, op1, op2;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] ctrl;
  } ex_t;

  int checks = 0;
  int failures = 0;
  ex_t exp_q[$];
  ex_t m;
  logic [31:0] rf_mem [32];
  logic last_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [15:0] ctrl);
    stim_t s;
    s.valid = 1'b1; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.imm = $urandom; s.ctrl = ctrl;
    s.wb_we = 1'b0; s.wb_rd = '0; s.wb_data = '0;
    s.stall = 1'b0; s.flush = 1'b0;
    return s;
  endfunction

  // One ID cycle: apply inputs, check id_hold, predict EX after the coming edge.
  task automatic drive(input stim_t s);
    logic lu;
    logic exp_hold;
    @(negedge clk);
    stall = s.stall; flush = s.flush; id_valid = s.valid; id_pc = s.pc;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_imm = s.imm; id_ctrl = s.ctrl;
    wb_we = s.wb_we; wb_rd = s.wb_rd; wb_data = s.wb_data;
    rf_rd1 = rf_mem[s.rs1]; rf_rd2 = rf_mem[s.rs2];
    #1;
    // ID reads a register the load in EX has not produced yet
    lu = s.valid && m.valid && m.ctrl[0] && (m.rd != 5'd0) && (m.rd == s.rs1 || m.rd == s.rs2);
    exp_hold = s.stall | lu;
    check("id_hold", {31'd0, id_hold}, {31'd0, exp_hold});
    last_hold = exp_hold;
    // Architectural view once this write-back retires; x0 is never written
    if (s.wb_we && s.wb_rd != 5'd0) rf_mem[s.wb_rd] = s.wb_data;
    if (s.flush) begin
      m.valid = 1'b0;
    end else if (s.stall) begin
      m.valid = m.valid;
    end else if (lu) begin
      m.valid = 1'b0;
      m.ctrl = '0;
    end else begin
      m.valid = s.valid; m.pc = s.pc; m.imm = s.imm;
      m.rs1 = s.rs1; m.rs2 = s.rs2; m.rd = s.rd; m.ctrl = s.ctrl;
      m.op1 = (s.rs1 == 5'd0) ? 32'd0 : rf_mem[s.rs1];
      m.op2 = (s.rs2 == 5'd0) ? 32'd0 : rf_mem[s.rs2];
    end
    exp_q.push_back(m);
  endtask

  initial begin : monitor
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        check("ex_pc", ex_pc, e.pc);
        check("ex_imm", ex_imm, e.imm);
        check("ex_rs1", {27'd0, ex_rs1}, {27'd0, e.rs1});
        check("ex_rs2", {27'd0, ex_rs2}, {27'd0, e.rs2});
        check("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
        check("ex_ctrl", {16'd0, ex_ctrl}, {16'd0, e.ctrl});
        check("ex_op1", ex_op1, e.op1);
        check("ex_op2", ex_op2, e.op2);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s, cur;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    m = '{valid: 1'b0, pc: '0, imm: '0, op1: '0, op2: '0, rs1: '0, rs2: '0, rd: '0, ctrl: '0};

    // Reset state, id_hold gated by rst even with stall high
    stall = 1'b1;
    @(posedge clk);
    #2;
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_op1", ex_op1, 32'd0);
    check("rst_ex_ctrl", {16'd0, ex_ctrl}, 32'd0);
    check("rst_id_hold", {31'd0, id_hold}, 32'd0);
    rst = 1'b0;
    stall = 1'b0;

    // Asynchronous reset in the middle of a cycle
    rf_mem[3] = 32'h55;
    drive(mk(32'h100, 5'd3, 5'd4, 5'd9, 16'h0002));
    @(posedge clk);
    #3;
    rst = 1'b1;
    stall = 1'b1;
    #1;
    check("midrst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("midrst_ex_op1", ex_op1, 32'd0);
    check("midrst_id_hold", {31'd0, id_hold}, 32'd0);
    m = '{valid: 1'b0, pc: '0, imm: '0, op1: '0, op2: '0, rs1: '0, rs2: '0, rd: '0, ctrl: '0};
    #1;
    rst = 1'b0;
    stall = 1'b0;
    drive(mk(32'h104, 5'd3, 5'd1, 5'd10, 16'h0000));

    // Write-back bypass, then same with bypass disabled
    rf_mem[5] = 32'h11;
    s = mk(32'h200, 5'd5, 5'd6, 5'd11, 16'h0002);
    s.wb_we = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'hABCD;
    drive(s);
    rf_mem[5] = 32'h11;
    s = mk(32'h204, 5'd5, 5'd6, 5'd11, 16'h0002);
    s.wb_we = 1'b0; s.wb_rd = 5'd5; s.wb_data = 32'hABCD;
    drive(s);

    // x0 wins over RF content and a write-back to x0
    rf_mem[0] = 32'hDEAD;
    s = mk(32'h208, 5'd1, 5'd0, 5'd12, 16'h0002);
    s.wb_we = 1'b1; s.wb_rd = 5'd0; s.wb_data = 32'h1234;
    drive(s);

    // Load-use: one bubble, then the held instruction enters EX
    drive(mk(32'h300, 5'd1, 5'd2, 5'd7, 16'h0001));
    s = mk(32'h304, 5'd2, 5'd7, 5'd8, 16'h0002);
    drive(s);
    drive(s);
    // Load to x0 never stalls
    drive(mk(32'h308, 5'd1, 5'd2, 5'd0, 16'h0001));
    drive(mk(32'h30c, 5'd3, 5'd0, 5'd8, 16'h0002));

    // Stall for 3 cycles with changing ID inputs
    for (int i = 0; i < 3; i++) begin
      s = mk(32'h400 + 32'(i * 4), 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
             5'($urandom_range(1, 31)), 16'($urandom));
      s.stall = 1'b1;
      drive(s);
    end
    // Stall with flush: flush wins
    s = mk(32'h40c, 5'd1, 5'd2, 5'd3, 16'h0002);
    s.stall = 1'b1; s.flush = 1'b1;
    drive(s);

    // Flush with load-use: single bubble then normal load
    drive(mk(32'h500, 5'd1, 5'd2, 5'd7, 16'h0001));
    s = mk(32'h504, 5'd7, 5'd3, 5'd9, 16'h0002);
    s.flush = 1'b1;
    drive(s);
    s.flush = 1'b0;
    drive(s);

    // Back-to-back stream without hazards
    for (int i = 0; i < 4; i++) begin
      drive(mk(32'h600 + 32'(i * 4), 5'(i + 1), 5'(i + 10), 5'(i + 20), 16'h0002));
    end

    // Randomized traffic; a held ID instruction is re-presented as the front end would
    cur = mk(32'h1000, 5'd1, 5'd2, 5'd3, 16'h0000);
    for (int n = 0; n < 300; n++) begin
      if (!last_hold) begin
        cur = mk(32'h1000 + 32'(n * 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 16'($urandom));
        cur.valid = ($urandom_range(0, 9) != 0);
      end
      cur.stall = ($urandom_range(0, 9) == 0);
      cur.flush = ($urandom_range(0, 9) == 0);
      cur.wb_we = $urandom_range(0, 1) == 1;
      cur.wb_rd = 5'($urandom_range(0, 7));
      cur.wb_data = $urandom;
      drive(cur);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
